// File: rtl/cpu_state_dump.sv
// ============================================================================
// Module   : cpu_state_dump
// Brief    : Streams a framed snapshot of registers, data memory and pipeline
//            counters over valid/ready. STATE_DUMP_CHECKSUM_EN appends an XOR word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_state_dump #(
    parameter int NUM_REGS      = 32,
    parameter int NUM_MEM_WORDS = 8,
    parameter int CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             dump_req_i,
    output logic             busy_o,
    output logic [4:0]       reg_addr_o,
    input  logic [31:0]      reg_data_i,
    output logic [31:0]      mem_addr_o,
    input  logic [31:0]      mem_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic [1:0]       out_tag_o,
    output logic             out_last_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int c_MAX_IDX = (NUM_REGS > NUM_MEM_WORDS) ? NUM_REGS : NUM_MEM_WORDS;
    localparam int c_IDX_W   = $clog2(c_MAX_IDX) + 1;
`ifdef STATE_DUMP_CHECKSUM_EN
    localparam int c_CNT_WORDS = 3;
`else
    localparam int c_CNT_WORDS = 2;
`endif
    localparam logic [c_IDX_W-1:0] c_REG_LAST = c_IDX_W'(NUM_REGS - 1);
    localparam logic [c_IDX_W-1:0] c_MEM_LAST = c_IDX_W'(NUM_MEM_WORDS - 1);
    localparam logic [c_IDX_W-1:0] c_CNT_DONE = c_IDX_W'(c_CNT_WORDS);
    localparam logic [1:0] c_TAG_HDR = 2'd0;
    localparam logic [1:0] c_TAG_REG = 2'd1;
    localparam logic [1:0] c_TAG_MEM = 2'd2;
    localparam logic [1:0] c_TAG_CNT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_REG  = 3'd2,
        S_MEM  = 3'd3,
        S_CNT  = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [CNT_W-1:0]     r_cyc, r_stall, r_flush;
    logic [CNT_W-1:0]     r_snap_cyc, r_snap_stall, r_snap_flush;
    logic                 r_valid, r_last;
    logic [31:0]          r_data;
    logic [1:0]           r_tag;
`ifdef STATE_DUMP_CHECKSUM_EN
    logic [31:0]          r_csum;
`endif

    logic                 w_can_load, w_hs;
    logic                 w_load, w_snap, w_drop, w_last;
    logic [31:0]          w_word;
    logic [1:0]           w_tag;

    assign w_can_load = ~r_valid | out_ready_i;
    assign w_hs       = r_valid & out_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        w_snap      = 1'b0;
        w_drop      = 1'b0;
        w_last      = 1'b0;
        w_word      = '0;
        w_tag       = c_TAG_HDR;
        case (r_state)
            S_IDLE: begin
                if (dump_req_i) begin
                    w_snap      = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (w_can_load) begin
                    w_load      = 1'b1;
                    w_word      = 32'(r_snap_cyc);
                    w_tag       = c_TAG_HDR;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_REG;
                end
            end
            S_REG: begin
                if (w_can_load) begin
                    w_load = 1'b1;
                    w_word = reg_data_i;
                    w_tag  = c_TAG_REG;
                    if (r_idx == c_REG_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_MEM;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_W'(1);
                    end
                end
            end
            S_MEM: begin
                if (w_can_load) begin
                    w_load = 1'b1;
                    w_word = mem_data_i;
                    w_tag  = c_TAG_MEM;
                    if (r_idx == c_MEM_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_CNT;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_W'(1);
                    end
                end
            end
            S_CNT: begin
                // Index past the last counter word means the final word is waiting for its handshake
                if (r_idx == c_CNT_DONE) begin
                    if (w_hs) begin
                        w_drop      = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_can_load) begin
                    w_load    = 1'b1;
                    w_tag     = c_TAG_CNT;
                    w_idx_nxt = r_idx + c_IDX_W'(1);
`ifdef STATE_DUMP_CHECKSUM_EN
                    if (r_idx == '0) begin
                        w_word = 32'(r_snap_stall);
                    end else if (r_idx == c_IDX_W'(1)) begin
                        w_word = 32'(r_snap_flush);
                    end else begin
                        w_word = r_csum;
                        w_last = 1'b1;
                    end
`else
                    if (r_idx == '0) begin
                        w_word = 32'(r_snap_stall);
                    end else begin
                        w_word = 32'(r_snap_flush);
                        w_last = 1'b1;
                    end
`endif
                end
            end
            default: begin
                w_idx_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cyc        <= '0;
            r_stall      <= '0;
            r_flush      <= '0;
            r_snap_cyc   <= '0;
            r_snap_stall <= '0;
            r_snap_flush <= '0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_tag        <= '0;
            r_last       <= 1'b0;
`ifdef STATE_DUMP_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            if (start_i) begin
                if (r_cyc != '1)                r_cyc   <= r_cyc + CNT_W'(1);
                if (stall_i && (r_stall != '1)) r_stall <= r_stall + CNT_W'(1);
                if (flush_i && (r_flush != '1)) r_flush <= r_flush + CNT_W'(1);
            end
            if (w_snap) begin
                r_snap_cyc   <= r_cyc;
                r_snap_stall <= r_stall;
                r_snap_flush <= r_flush;
`ifdef STATE_DUMP_CHECKSUM_EN
                r_csum       <= '0;
`endif
            end
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_word;
                r_tag   <= w_tag;
                r_last  <= w_last;
`ifdef STATE_DUMP_CHECKSUM_EN
                r_csum  <= r_csum ^ w_word;
`endif
            end else if (w_drop) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign busy_o      = (r_state != S_IDLE);
    assign reg_addr_o  = (r_state == S_REG) ? 5'(r_idx) : 5'd0;
    assign mem_addr_o  = (r_state == S_MEM) ? 32'({r_idx, 2'b00}) : 32'd0;
    assign out_valid_o = r_valid;
    assign out_data_o  = r_data;
    assign out_tag_o   = r_tag;
    assign out_last_o  = r_last;
    assign stall_cnt_o = r_stall;
    assign flush_cnt_o = r_flush;

endmodule

`default_nettype wire

// File: tb/tb_cpu_state_dump.sv
// ============================================================================
// Module   : tb_cpu_state_dump
// Brief    : Self-checking bench for cpu_state_dump against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_state_dump;

`ifdef STATE_DUMP_CHECKSUM_EN
    localparam int FRAME_LEN = 44;
`else
    localparam int FRAME_LEN = 43;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, start_i, stall_i, flush_i, dump_req_i, out_ready_i;
    logic        busy, out_valid, out_last;
    logic [4:0]  reg_addr;
    logic [31:0] mem_addr, out_data, reg_data, mem_data;
    logic [1:0]  out_tag;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_busy, s_valid, s_last;
    logic [4:0]  s_reg_addr;
    logic [31:0] s_mem_addr, s_data;
    logic [1:0]  s_tag;
    logic [2:0]  s_stall, s_flush;

    logic [31:0] regs [32];
    logic [31:0] mem  [8];

    assign reg_data = regs[reg_addr];
    assign mem_data = (mem_addr[31:5] == 27'd0 && mem_addr[1:0] == 2'd0) ? mem[mem_addr[4:2]] : 32'hDEAD_BEEF;

    cpu_state_dump dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .flush_i(flush_i),
        .dump_req_i(dump_req_i), .busy_o(busy), .reg_addr_o(reg_addr), .reg_data_i(reg_data),
        .mem_addr_o(mem_addr), .mem_data_i(mem_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready_i), .out_data_o(out_data), .out_tag_o(out_tag),
        .out_last_o(out_last), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    // Narrow-counter instance so saturation is reachable in a short run
    cpu_state_dump #(.CNT_W(3)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .flush_i(flush_i),
        .dump_req_i(1'b0), .busy_o(s_busy), .reg_addr_o(s_reg_addr), .reg_data_i(32'd0),
        .mem_addr_o(s_mem_addr), .mem_data_i(32'd0), .out_valid_o(s_valid),
        .out_ready_i(1'b1), .out_data_o(s_data), .out_tag_o(s_tag),
        .out_last_o(s_last), .stall_cnt_o(s_stall), .flush_cnt_o(s_flush)
    );

    int errors = 0;
    int checks = 0;

    longint m_cyc, m_stall, m_flush, snap_c, snap_s, snap_f;
    int     m_sat_s, m_sat_f;
    bit     m_busy;
    logic [31:0] e_data [$];
    logic [1:0]  e_tag  [$];
    bit          e_last [$];
    logic [31:0] got_q  [$];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock: advance the reference model from the inputs seen at this edge
    task automatic tick();
        bit s = start_i, st = stall_i, fl = flush_i, r = rst_i, d = dump_req_i;
        @(posedge clk);
        if (r) begin
            m_cyc = 0; m_stall = 0; m_flush = 0; m_sat_s = 0; m_sat_f = 0; m_busy = 0;
        end else begin
            if (d && !m_busy) begin
                snap_c = m_cyc; snap_s = m_stall; snap_f = m_flush; m_busy = 1;
            end
            if (s) begin
                if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
                if (st && m_stall < 64'hFFFF_FFFF) m_stall++;
                if (fl && m_flush < 64'hFFFF_FFFF) m_flush++;
                if (st && m_sat_s < 7) m_sat_s++;
                if (fl && m_sat_f < 7) m_sat_f++;
            end
        end
        #1;
    endtask

    task automatic build_exp();
        logic [31:0] x = 32'd0;
        e_data.delete(); e_tag.delete(); e_last.delete();
        e_data.push_back(snap_c[31:0]); e_tag.push_back(2'd0);
        for (int i = 0; i < 32; i++) begin e_data.push_back(regs[i]); e_tag.push_back(2'd1); end
        for (int i = 0; i < 8; i++)  begin e_data.push_back(mem[i]);  e_tag.push_back(2'd2); end
        e_data.push_back(snap_s[31:0]); e_tag.push_back(2'd3);
        e_data.push_back(snap_f[31:0]); e_tag.push_back(2'd3);
`ifdef STATE_DUMP_CHECKSUM_EN
        foreach (e_data[i]) x ^= e_data[i];
        e_data.push_back(x); e_tag.push_back(2'd3);
`endif
        foreach (e_data[i]) e_last.push_back(i == FRAME_LEN - 1);
    endtask

    task automatic start_dump(input bit keep);
        dump_req_i = 1'b1;
        tick();
        chk("accept_busy", busy, 1);
        chk("accept_valid", out_valid, 0);
        if (!keep) dump_req_i = 1'b0;
    endtask

    // Consume one frame; stop_after>0 returns right after that many handshakes are committed
    task automatic collect(input int stop_after, input bit rnd);
        int got = 0, cyc = 0, nvalid = 0;
        bit prev_stall = 0, seen = 0;
        logic [31:0] pd = '0;
        logic [1:0]  pt = '0;
        logic        pl = 1'b0;
        build_exp();
        got_q.delete();
        while (1) begin
            if (cyc > 600) begin
                chk("frame_timeout", got, FRAME_LEN);
                return;
            end
            out_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd) begin
                stall_i = 1'($urandom_range(0, 1));
                flush_i = 1'($urandom_range(0, 1));
            end
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pd);
                chk("hold_tag", out_tag, pt);
                chk("hold_last", out_last, pl);
            end
            if (out_valid) begin
                nvalid++;
                if (!seen) begin chk("hdr_latency", cyc, 1); seen = 1; end
                chk($sformatf("w%0d_data", got), out_data, e_data[got]);
                chk($sformatf("w%0d_tag", got), out_tag, e_tag[got]);
                chk($sformatf("w%0d_last", got), out_last, e_last[got]);
                prev_stall = !out_ready_i;
                pd = out_data; pt = out_tag; pl = out_last;
                if (out_ready_i) begin
                    got_q.push_back(out_data);
                    got++;
                    if (stop_after > 0 && got == stop_after) return;
                    if (got == FRAME_LEN) begin
                        tick();
                        chk("end_valid", out_valid, 0);
                        chk("end_busy", busy, 0);
                        m_busy = 0;
                        if (!rnd) chk("valid_cycles", nvalid, FRAME_LEN);
                        chk("live_stall", stall_cnt, m_stall[31:0]);
                        chk("live_flush", flush_cnt, m_flush[31:0]);
                        return;
                    end
                end
            end else begin
                prev_stall = 0;
            end
            tick();
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1; start_i = 0; stall_i = 0; flush_i = 0; dump_req_i = 0; out_ready_i = 0;
        m_busy = 0; snap_c = 0; snap_s = 0; snap_f = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        for (int i = 0; i < 8; i++)  mem[i] = 32'd0;
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_last", out_last, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_flush", flush_cnt, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst_i = 0;

        // Counters: 10 running cycles with 3 stalls and 2 flushes, then 4 idle cycles
        for (int c = 0; c < 10; c++) begin
            start_i = 1;
            stall_i = (c == 2 || c == 5 || c == 7);
            flush_i = (c == 3 || c == 8);
            tick();
        end
        start_i = 0; stall_i = 1; flush_i = 1;
        for (int c = 0; c < 4; c++) tick();
        stall_i = 0; flush_i = 0;
        chk("cnt_stall", stall_cnt, 3);
        chk("cnt_flush", flush_cnt, 2);

        // Full dump with fixed contents and sink always ready
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
        for (int i = 0; i < 8; i++)  mem[i] = 32'd0;
        mem[0] = 32'd5; mem[7] = 32'h1122_3344;
        start_dump(0);
        collect(0, 0);
        chk("frame_len", got_q.size(), FRAME_LEN);
        if (got_q.size() >= 41) begin
            chk("hdr_cycle10", got_q[0], 10);
            chk("word1", got_q[1], 0);
            chk("word32", got_q[32], 93);
            chk("word33", got_q[33], 5);
            chk("word40", got_q[40], 32'h1122_3344);
        end

        // Backpressure with random contents and live counter activity
        for (int i = 0; i < 32; i++) regs[i] = $urandom();
        for (int i = 0; i < 8; i++)  mem[i] = $urandom();
        start_i = 1;
        for (int c = 0; c < 5; c++) begin stall_i = 1'($urandom_range(0, 1)); flush_i = 1'($urandom_range(0, 1)); tick(); end
        start_dump(0);
        collect(0, 1);

        // Request held high across a frame: one frame, then a fresh one
        stall_i = 0; flush_i = 0;
        start_dump(1);
        collect(0, 1);
        start_dump(0);
        collect(0, 1);

        // Reset mid-dump after word 20
        for (int i = 0; i < 32; i++) regs[i] = $urandom();
        start_dump(0);
        collect(21, 0);
        rst_i = 1;
        tick();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_last", out_last, 0);
        chk("mrst_stall", stall_cnt, 0);
        chk("mrst_flush", flush_cnt, 0);
        rst_i = 0; start_i = 1; stall_i = 1; flush_i = 0;
        for (int c = 0; c < 3; c++) tick();
        stall_i = 0;
        start_dump(0);
        collect(0, 0);

        // All-zero state with cycle snapshot 7
        rst_i = 1; start_i = 0; tick(); rst_i = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        for (int i = 0; i < 8; i++)  mem[i] = 32'd0;
        start_i = 1;
        for (int c = 0; c < 7; c++) tick();
        start_i = 0;
        start_dump(0);
        collect(0, 0);
        chk("zero_len", got_q.size(), FRAME_LEN);
        if (got_q.size() == FRAME_LEN) begin
            chk("zero_hdr", got_q[0], 7);
`ifdef STATE_DUMP_CHECKSUM_EN
            chk("checksum", got_q[43], 7);
`endif
        end

        // Saturation on the narrow-counter instance
        rst_i = 1; tick(); rst_i = 0;
        start_i = 1; stall_i = 1; flush_i = 1;
        for (int c = 0; c < 10; c++) tick();
        start_i = 0; stall_i = 0; flush_i = 0;
        chk("sat_stall", {29'd0, s_stall}, 32'(m_sat_s));
        chk("sat_flush", {29'd0, s_flush}, 7);
        chk("wide_stall", stall_cnt, 10);
        tick();
        chk("sat_hold", {29'd0, s_stall}, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_state_dump.md
Name: cpu_state_dump

Overview:
- In-design reader of architectural state; the hardware counterpart of the bench's per-cycle register, memory and stall/flush printout.
- On a dump request, walks the register-file and data-memory read ports and streams a framed snapshot over a valid/ready interface.
- Maintains cycle, stall and flush counters fed from the CPU's hazard and flush logic.
- Sits beside CPU; taps a spare register-file read port and a spare data-memory read port.

Parameters:
- NUM_REGS, 32, register-file entries dumped (x0..x31).
- NUM_MEM_WORDS, 8, 32-bit data-memory words dumped, starting at byte 0x00.
- CNT_W, 32, width of the cycle, stall and flush counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  CPU running; counters advance only while high.
- stall_i  in  1  pipeline stall this cycle.
- flush_i  in  1  pipeline flush this cycle.
- dump_req_i  in  1  request a snapshot; level-sampled in IDLE only.
- busy_o  out  1  high from acceptance through the final handshake.
- reg_addr_o  out  5  register-file read address.
- reg_data_i  in  32  combinational read data for reg_addr_o.
- mem_addr_o  out  32  data-memory byte address, always word-aligned.
- mem_data_i  in  32  combinational little-endian word at mem_addr_o.
- out_valid_o  out  1  stream word valid.
- out_ready_i  in  1  sink ready.
- out_data_o  out  32  stream word.
- out_tag_o  out  2  word type: 0 header, 1 register, 2 memory, 3 counter.
- out_last_o  out  1  marks the final word of the frame.
- stall_cnt_o  out  CNT_W  live stall count.
- flush_cnt_o  out  CNT_W  live flush count.

Behaviour:
- Reset: all outputs and counters are 0. The FSM returns to IDLE. A frame in progress is abandoned; no last word is emitted.
- Counters: each clock with start_i=1, cycle_cnt increments by 1. stall_cnt increments when stall_i=1. flush_cnt increments when flush_i=1. All counters saturate at 2^CNT_W-1 and never wrap.
- Counters keep running during a dump.
- FSM states: IDLE, HDR, REG, MEM, CNT.
- IDLE: when dump_req_i=1 at edge N, snapshot cycle_cnt, stall_cnt and flush_cnt (values before edge N's increment). Set busy_o at N.
- out_valid_o rises after edge N+1, carrying the header word (tag 0, data = cycle snapshot).
- Frame order:
  - header;
  - registers 0..NUM_REGS-1 (tag 1);
  - memory words at byte addresses 0,4,...,4*(NUM_MEM_WORDS-1) (tag 2);
  - stall snapshot, then flush snapshot (tag 3).
  - Default frame length is 43 words.
- Read timing: reg_addr_o and mem_addr_o present the index of the next word to load. Read data is captured into the output register on the load edge, so read latency is 0.
- Load condition: the output register loads when out_valid_o=0 or when out_valid_o and out_ready_i are both 1.
- Throughput: one word per cycle while out_ready_i stays high.
- Stability: while out_valid_o=1 and out_ready_i=0, out_data_o, out_tag_o and out_last_o hold stable. out_valid_o never drops without a handshake.
- Register and memory values are sampled at their individual load edges, not atomically. CPU writes during a dump are visible if they land before that word is loaded.
- out_last_o is 1 only on the flush word.
- The cycle after the last handshake: out_valid_o=0, busy_o=0, state IDLE. A new request is accepted on the next edge at the earliest.
- dump_req_i outside IDLE is ignored; it is not queued.
- Unused address bits drive 0.
- Register 0 is emitted as read; it is not forced to 0.

Optional Feature:
- Macro: STATE_DUMP_CHECKSUM_EN.
- Defined: one extra word follows the flush word. It has tag 3 and data equal to the XOR of all preceding frame words. out_last_o moves to this word; frame length is 44.
- Undefined: no checksum logic; frame length is 43, with out_last_o on the flush word.

Test Plan:
- Counters: 10 cycles with start_i=1, stall_i=1 on 3 cycles, flush_i=1 on 2 cycles, then 4 cycles with start_i=0 -> stall_cnt_o=3, flush_cnt_o=2, cycle snapshot 10 on a subsequent dump.
- Full dump: regs preloaded x[i]=i*3, mem words 5,0,0,0,0,0,0,0x11223344, out_ready_i held 1 -> 43 consecutive valid cycles.
  - Word 1 = 0 (tag 1); word 32 = 93.
  - Word 33 = 5 (tag 2); word 40 = 0x11223344.
  - out_last_o only on word 42.
- Backpressure: toggle out_ready_i pseudo-randomly -> no word lost or duplicated, and data/tag hold stable while stalled.
- Request while busy: dump_req_i=1 throughout a frame -> exactly one frame, then a second header starting 2 cycles after the last handshake.
- Reset mid-dump: assert rst_i after word 20 -> out_valid_o=0, busy_o=0 and all counters 0 after that edge; a new dump restarts from the header.
- With STATE_DUMP_CHECKSUM_EN: all regs 0, mem 0, counters 0 at request, cycle snapshot 7 -> word 43 = 7, out_last_o=1 on word 43 only.
